// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Drives en/flush of IFID, IDEX, EXMEM, MEMWB and the PC load enable.
// Handles memory freezes, load-use bubbles, taken-branch redirects and a
// post-reset pipeline clear.
// Optional build macro: HAZARD_PERF_CNT_EN enables saturating performance
// counters (stall_mem_cnt, stall_lu_cnt, flush_cnt); otherwise they read 0.
module pipeline_hazard_ctrl #(
    parameter int CNT_W             = 32,
    parameter int INIT_FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_read,
    input  logic             dmem_write,
    input  logic             dmem_resp,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic             br_taken_ex,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [CNT_W-1:0] stall_mem_cnt,
    output logic [CNT_W-1:0] stall_lu_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int IW = (INIT_FLUSH_CYCLES > 1) ? $clog2(INIT_FLUSH_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_INIT      = 2'd0,
        S_RUN       = 2'd1,
        S_MEM_STALL = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] init_cnt_q, init_cnt_d;
    logic          imem_done_q, imem_done_d;
    logic          dmem_done_q, dmem_done_d;

    logic mem_pending_i;
    logic mem_pending_d;
    logic busy;
    logic load_use;

    // Outstanding-access and load-use hazard detection.
    always_comb begin
        mem_pending_i = imem_read & ~(imem_resp | imem_done_q);
        mem_pending_d = (dmem_read | dmem_write) & ~(dmem_resp | dmem_done_q);
        busy          = mem_pending_i | mem_pending_d;
        load_use      = idex_mem_read & (idex_rd != 5'd0) &
                        ((ifid_use_rs1 & (ifid_rs1 == idex_rd)) |
                         (ifid_use_rs2 & (ifid_rs2 == idex_rd)));
    end

    // Next-state, sticky-response tracking and stage control outputs.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        imem_done_d = imem_done_q;
        dmem_done_d = dmem_done_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        if (!rst) begin
            case (state_q)
                S_INIT: begin
                    ifid_en     = 1'b1;
                    idex_en     = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    memwb_flush = 1'b1;
                    imem_done_d = 1'b0;
                    dmem_done_d = 1'b0;
                    if (init_cnt_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        init_cnt_d = init_cnt_q - IW'(1);
                    end
                end
                S_RUN, S_MEM_STALL: begin
                    if (busy) begin
                        // Freeze everything; remember responses that land
                        // while the other side is still outstanding.
                        state_d     = S_MEM_STALL;
                        imem_done_d = imem_done_q | (imem_read & imem_resp);
                        dmem_done_d = dmem_done_q | ((dmem_read | dmem_write) & dmem_resp);
                    end else begin
                        state_d     = S_RUN;
                        imem_done_d = 1'b0;
                        dmem_done_d = 1'b0;
                        if (br_taken_ex) begin
                            // Redirect: squash the two wrong-path stages.
                            pc_en      = 1'b1;
                            ifid_en    = 1'b1;
                            idex_en    = 1'b1;
                            exmem_en   = 1'b1;
                            memwb_en   = 1'b1;
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end else if (load_use) begin
                            // Hold PC and IFID, inject a bubble into IDEX.
                            idex_en    = 1'b1;
                            exmem_en   = 1'b1;
                            memwb_en   = 1'b1;
                            idex_flush = 1'b1;
                        end else begin
                            pc_en    = 1'b1;
                            ifid_en  = 1'b1;
                            idex_en  = 1'b1;
                            exmem_en = 1'b1;
                            memwb_en = 1'b1;
                        end
                    end
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_cnt_q  <= INIT_LOAD;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_mem_cnt_q, stall_mem_cnt_d;
    logic [CNT_W-1:0] stall_lu_cnt_q, stall_lu_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             run_cyc;

    // Saturating event counters; INIT cycles are never counted.
    always_comb begin
        run_cyc         = (state_q == S_RUN) || (state_q == S_MEM_STALL);
        stall_mem_cnt_d = stall_mem_cnt_q;
        stall_lu_cnt_d  = stall_lu_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        if (run_cyc && busy && (stall_mem_cnt_q != '1)) begin
            stall_mem_cnt_d = stall_mem_cnt_q + CNT_W'(1);
        end
        if (run_cyc && !busy && br_taken_ex && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (run_cyc && !busy && !br_taken_ex && load_use && (stall_lu_cnt_q != '1)) begin
            stall_lu_cnt_d = stall_lu_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_mem_cnt_q <= '0;
            stall_lu_cnt_q  <= '0;
            flush_cnt_q     <= '0;
        end else begin
            stall_mem_cnt_q <= stall_mem_cnt_d;
            stall_lu_cnt_q  <= stall_lu_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign stall_mem_cnt = stall_mem_cnt_q;
    assign stall_lu_cnt  = stall_lu_cnt_q;
    assign flush_cnt     = flush_cnt_q;
`else
    assign stall_mem_cnt = '0;
    assign stall_lu_cnt  = '0;
    assign flush_cnt     = '0;
`endif

endmodule
